// File: rtl/sap_sequencer_if.sv
// Control-side bundle between the SAP sequencer and its datapath/IR.
// The master drives opcode, flags and run/step; the slave returns control.
interface sap_sequencer_if #(
   parameter int OP_W = 4
);
   logic [OP_W-1:0] instruction;
   logic            carry_flag;
   logic            zero_flag;
   logic            run;
   logic            step;
   logic [15:0]     control;
   logic [2:0]      t_state;
   logic            instr_done;
   logic            halted;
   logic            illegal;

   modport master (
      output instruction, carry_flag, zero_flag, run, step,
      input  control, t_state, instr_done, halted, illegal
   );

   modport slave (
      input  instruction, carry_flag, zero_flag, run, step,
      output control, t_state, instr_done, halted, illegal
   );
endinterface

// File: rtl/sap_sequencer.sv
// Variable-length SAP micro-sequencer: fetch T1/T2, execute T3..T5,
// run/single-step parking in IDLE and a sticky HALT left only by reset.
module sap_sequencer #(
   parameter int OP_W      = 4,
   parameter bit FIXED_LEN = 1'b0
) (
   input logic         clk,
   input logic         reset,
   sap_sequencer_if.slave bus
);

   localparam logic [15:0] C_HLT  = 16'h8000;
   localparam logic [15:0] C_PCI  = 16'h4000;
   localparam logic [15:0] C_PCO  = 16'h2000;
   localparam logic [15:0] C_PCL  = 16'h1000;
   localparam logic [15:0] C_MARL = 16'h0800;
   localparam logic [15:0] C_RAMO = 16'h0400;
   localparam logic [15:0] C_RAML = 16'h0200;
   localparam logic [15:0] C_IRL  = 16'h0100;
   localparam logic [15:0] C_IRO  = 16'h0080;
   localparam logic [15:0] C_AL   = 16'h0040;
   localparam logic [15:0] C_AO   = 16'h0020;
   localparam logic [15:0] C_BL   = 16'h0010;
   localparam logic [15:0] C_SUB  = 16'h0008;
   localparam logic [15:0] C_ALUO = 16'h0004;
   localparam logic [15:0] C_OUTL = 16'h0002;
   localparam logic [15:0] C_FLG  = 16'h0001;

   // Encoding chosen so T1..T5 equal their t_state number.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_nxt;
   logic [3:0]  w_op;
   logic        w_hi_bad;
   logic        w_legal;
   logic        w_hlt;
   logic [2:0]  w_len;
   logic [2:0]  w_end;
   logic        w_t3;
   logic        w_t4;
   logic        w_t5;
   logic        w_exec;
   logic        w_last;
   logic [15:0] w_ctl;

   assign w_op = bus.instruction[3:0];

   generate
      if (OP_W > 4) begin : g_hi
         assign w_hi_bad = |bus.instruction[OP_W-1:4];
      end else begin : g_no_hi
         assign w_hi_bad = 1'b0;
      end
   endgenerate

   assign w_t3   = (r_state == S_T3);
   assign w_t4   = (r_state == S_T4);
   assign w_t5   = (r_state == S_T5);
   assign w_exec = w_t3 | w_t4 | w_t5;

   always_comb begin
      w_ctl   = '0;
      w_len   = 3'd3;
      w_hlt   = 1'b0;
      w_legal = ~w_hi_bad;
      unique case (r_state)
         S_T1:   w_ctl = C_PCO | C_MARL;
         S_T2:   w_ctl = C_RAMO | C_IRL | C_PCI;
         S_HALT: w_ctl = C_HLT;
         default: ;
      endcase
      if (w_exec && !w_hi_bad) begin
         case (w_op)
            4'h0: ;
            4'h1: begin
               w_len = 3'd4;
               if (w_t3) w_ctl = C_IRO | C_MARL;
               if (w_t4) w_ctl = C_RAMO | C_AL;
            end
            4'h2, 4'h3: begin
               w_len = 3'd5;
               if (w_t3) w_ctl = C_IRO | C_MARL;
               if (w_t4) w_ctl = C_RAMO | C_BL;
               if (w_t5) w_ctl = C_ALUO | C_AL | C_FLG
                               | ((w_op == 4'h3) ? C_SUB : 16'h0);
            end
            4'h4: begin
               w_len = 3'd4;
               if (w_t3) w_ctl = C_IRO | C_MARL;
               if (w_t4) w_ctl = C_AO | C_RAML;
            end
            4'h5: if (w_t3) w_ctl = C_IRO | C_AL;
            4'h6: if (w_t3) w_ctl = C_IRO | C_PCL;
            4'h7: if (w_t3 && bus.carry_flag) w_ctl = C_IRO | C_PCL;
            4'h8: if (w_t3 && bus.zero_flag) w_ctl = C_IRO | C_PCL;
            4'hE: if (w_t3) w_ctl = C_AO | C_OUTL;
            4'hF: begin
               w_hlt = 1'b1;
               if (w_t3) w_ctl = C_HLT;
            end
            default: w_legal = 1'b0;
         endcase
      end
   end

   assign w_end  = FIXED_LEN ? 3'd5 : w_len;
   assign w_last = w_exec && (r_state[2:0] == w_end);

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (bus.run || bus.step) w_nxt = S_T1;
         S_T1:   w_nxt = S_T2;
         S_T2:   w_nxt = S_T3;
         S_T3, S_T4, S_T5: begin
            if (w_t3 && w_hlt)
               w_nxt = S_HALT;
            else if (w_last)
               w_nxt = bus.run ? S_T1 : S_IDLE;
            else if (w_t3)
               w_nxt = S_T4;
            else
               w_nxt = S_T5;
         end
         S_HALT: w_nxt = S_HALT;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   assign bus.control    = w_ctl;
   assign bus.t_state    = (w_exec || r_state == S_T1 || r_state == S_T2)
                           ? r_state[2:0] : 3'd0;
   assign bus.instr_done = w_last && !w_hlt;
   assign bus.halted     = (r_state == S_HALT);
   assign bus.illegal    = w_t3 && !w_legal;

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Parametrised micro-sequencer that drives the SAP datapath control word. It replaces fixed six-T-state sequencing with variable-length instructions, which saves cycles on short instructions. It adds conditional jumps on carry/zero, STA/LDI/OUT/JMP instructions, a run/single-step mode and an explicit halted state. It sits between the instruction register's opcode field and every datapath load/enable input.

## Interface
Parameters:
- OP_W, 4: opcode input width (≥4); opcode decoded from instruction[3:0], any nonzero instruction[OP_W-1:4] is illegal.
- FIXED_LEN, 0: 1 pads every non-HLT instruction to 5 T-states (legacy timing); 0 ends each instruction at its last useful T-state.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clock clk.
- instruction  in  OP_W  opcode field from IR; valid from T3 until instruction end.
- carry_flag  in  1  registered ALU carry, used by JC.
- zero_flag  in  1  registered ALU zero, used by JZ.
- run  in  1  level; 1 = free-running, 0 = park between instructions.
- step  in  1  one-cycle pulse; releases exactly one instruction while parked.
- control  out  16  active-high control word, combinational from state/instruction/flags. Bits: 15 HLT, 14 PC_INC, 13 PC_OUT, 12 PC_LOAD, 11 MAR_LOAD, 10 RAM_OUT, 9 RAM_LOAD, 8 IR_LOAD, 7 IR_OUT, 6 A_LOAD, 5 A_OUT, 4 B_LOAD, 3 ALU_SUB, 2 ALU_OUT, 1 OUT_LOAD, 0 FLAG_LOAD.
- t_state  out  3  1..5 in T1..T5, 0 in IDLE/HALT.
- instr_done  out  1  high during last T-state of each completed non-HLT instruction.
- halted  out  1  high in HALT.
- illegal  out  1  high during T3 of an undefined opcode.

## Operation
- States: IDLE, T1..T5, HALT. Reset → IDLE; all outputs 0.
- IDLE: control=0. Next edge → T1 if run=1 or step=1, else stay.
- Fetch, all opcodes: T1 PC_OUT|MAR_LOAD; T2 RAM_OUT|IR_LOAD|PC_INC.
- Execute, T3 onward:
  - 0000 NOP: T3 none.
  - 0001 LDA: T3 IR_OUT|MAR_LOAD; T4 RAM_OUT|A_LOAD.
  - 0010 ADD: T3 IR_OUT|MAR_LOAD; T4 RAM_OUT|B_LOAD; T5 ALU_OUT|A_LOAD|FLAG_LOAD.
  - 0011 SUB: same as ADD, plus ALU_SUB in T5.
  - 0100 STA: T3 IR_OUT|MAR_LOAD; T4 A_OUT|RAM_LOAD.
  - 0101 LDI: T3 IR_OUT|A_LOAD.
  - 0110 JMP: T3 IR_OUT|PC_LOAD.
  - 0111 JC: T3 IR_OUT|PC_LOAD if carry_flag, else none.
  - 1000 JZ: same as JC, gated by zero_flag.
  - 1110 OUT: T3 A_OUT|OUT_LOAD.
  - 1111 HLT: T3 HLT, then HALT.
  - Opcodes 1001–1101 or nonzero upper bits: NOP behaviour plus illegal.
- Last T-state: instr_done=1. Next state T1 if run=1, else IDLE. step pulses outside IDLE are ignored.
- FIXED_LEN=1: after the last useful step, extra T-states up to T5 carry control=0. instr_done moves to T5.
- HALT: control=HLT bit only; halted=1; t_state=0. Ignores run/step. Left only via reset.

## Timing
- Instruction lengths (FIXED_LEN=0): NOP/LDI/JMP/JC/JZ/OUT 3, LDA/STA 4, ADD/SUB 5 cycles. HLT takes 3 cycles, then HALT.
- instruction and flags are sampled combinationally in T3..T5; they must be stable before the rising edge that ends each T-state. IR loads on the edge ending T2.
- JC/JZ decide from flag values present during T3. A FLAG_LOAD in the preceding ADD's T5 is visible here.
- Reset mid-instruction: immediate IDLE with control=0; no partial step completes.
- run falling mid-instruction: the instruction finishes, then parks in IDLE. run and step both high in IDLE: same as run.

## Test plan
- Reset, run=1, instruction=0001 (LDA): t_state 1,2,3,4,1. control 0x2800, 0x4500, 0x0880, 0x0440. instr_done only in T4.
- ADD then SUB: T5 control=0x0045 for ADD and 0x004D for SUB. 5 cycles each.
- JC with carry_flag=0: T3 control=0x0000. With carry_flag=1: T3 control=0x1080. Both 3 cycles.
- HLT: T3 control=0x8000, then halted=1, control=0x8000 held 20 cycles regardless of run/step. reset low → IDLE, halted=0.
- run=0 after reset: stays IDLE 10 cycles. One step pulse executes exactly one NOP (T1..T3), then returns to IDLE. step during T2 is ignored.
- FIXED_LEN=1, LDI: T4 and T5 control=0; instr_done in T5. Opcode 1010: illegal=1 in T3, behaves as NOP.
